// File: rtl/dense_argmax_pkg.sv
// Shared constants and types for the dense_4 argmax classifier stage.
// Build option: DENSE_ARGMAX_MARGIN_EN enables top1-top2 margin tracking.
`timescale 1ns/1ps
package dense_argmax_pkg;

  localparam int N_CLASSES = 5;
  localparam int DATA_W    = 21;
  localparam int NFRAC     = 10;
  localparam int IDX_W     = $clog2(N_CLASSES);

  typedef logic signed [DATA_W-1:0] logit_t;
  typedef logic [IDX_W-1:0]         idx_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logit_t LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam idx_t   LAST_IDX  = idx_t'(N_CLASSES - 1);

endpackage

// File: rtl/dense_argmax_cmp.sv
// One scan step: folds a candidate logit into the running best (and second best).
// Build option: DENSE_ARGMAX_MARGIN_EN adds the second-best path.
`timescale 1ns/1ps
module dense_argmax_cmp
  import dense_argmax_pkg::*;
(
  input  logit_t i_cand,
  input  idx_t   i_cand_idx,
  input  logit_t i_best,
  input  idx_t   i_best_idx,
`ifdef DENSE_ARGMAX_MARGIN_EN
  input  logit_t i_second,
  output logit_t o_next_second,
`endif
  output logit_t o_next_best,
  output idx_t   o_next_idx
);

  // Strictly greater wins, so ties keep the earlier (lower) class index.
  always_comb begin
    o_next_best = i_best;
    o_next_idx  = i_best_idx;
`ifdef DENSE_ARGMAX_MARGIN_EN
    o_next_second = i_second;
`endif
    if (i_cand > i_best) begin
      o_next_best = i_cand;
      o_next_idx  = i_cand_idx;
`ifdef DENSE_ARGMAX_MARGIN_EN
      o_next_second = i_best;
`endif
    end
`ifdef DENSE_ARGMAX_MARGIN_EN
    else if (i_cand > i_second) begin
      o_next_second = i_cand;
    end
`endif
  end

endmodule

// File: rtl/dense_4_argmax.sv
// Serial argmax over the dense_4 logit vector with valid/ready on both sides.
// Build option: DENSE_ARGMAX_MARGIN_EN drives out_margin; otherwise it is 0.
`timescale 1ns/1ps
module dense_4_argmax
  import dense_argmax_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_CLASSES*DATA_W-1:0] in_logits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_idx,
  output logic signed [DATA_W-1:0]    out_max,
  output logic [DATA_W:0]             out_margin
);

  state_t r_state;
  logic   r_in_ready;
  logic   r_out_valid;
  idx_t   r_cnt;
  idx_t   r_idx;
  logit_t r_best;
  logit_t r_logits [N_CLASSES];

  logit_t w_next_best;
  idx_t   w_next_idx;

`ifdef DENSE_ARGMAX_MARGIN_EN
  logit_t           r_second;
  logic [DATA_W:0]  r_margin;
  logit_t           w_next_second;
  logic [DATA_W:0]  w_margin;

  // Sign-extend by one bit so best - second (max 2^DATA_W - 1) never wraps.
  assign w_margin = {w_next_best[DATA_W-1], w_next_best}
                  - {w_next_second[DATA_W-1], w_next_second};
`endif

  dense_argmax_cmp u_cmp (
    .i_cand        (r_logits[r_cnt]),
    .i_cand_idx    (r_cnt),
    .i_best        (r_best),
    .i_best_idx    (r_idx),
`ifdef DENSE_ARGMAX_MARGIN_EN
    .i_second      (r_second),
    .o_next_second (w_next_second),
`endif
    .o_next_best   (w_next_best),
    .o_next_idx    (w_next_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_best      <= '0;
      for (int k = 0; k < N_CLASSES; k++) r_logits[k] <= '0;
`ifdef DENSE_ARGMAX_MARGIN_EN
      r_second    <= '0;
      r_margin    <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            for (int k = 0; k < N_CLASSES; k++)
              r_logits[k] <= in_logits[k*DATA_W +: DATA_W];
            r_best     <= in_logits[0 +: DATA_W];
            r_idx      <= '0;
            r_cnt      <= idx_t'(1);
`ifdef DENSE_ARGMAX_MARGIN_EN
            r_second   <= LOGIT_MIN;
`endif
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_best <= w_next_best;
          r_idx  <= w_next_idx;
`ifdef DENSE_ARGMAX_MARGIN_EN
          r_second <= w_next_second;
`endif
          if (r_cnt == LAST_IDX) begin
`ifdef DENSE_ARGMAX_MARGIN_EN
            r_margin <= w_margin;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + idx_t'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_idx;
  assign out_max   = r_best;
`ifdef DENSE_ARGMAX_MARGIN_EN
  assign out_margin = r_margin;
`else
  assign out_margin = '0;
`endif

endmodule

// File: tb/tb_dense_4_argmax.sv
// Self-checking bench for dense_4_argmax: directed vectors, random vectors,
// back-pressure and reset abort, against a two-pass argmax reference model.
`timescale 1ns/1ps
module tb_dense_4_argmax;

  localparam int NC = 5;
  localparam int W  = 21;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NC*W-1:0]   in_logits;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_idx;
  logic signed [W-1:0] out_max;
  logic [W:0]        out_margin;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc;

  dense_4_argmax dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_logits  (in_logits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_max    (out_max),
    .out_margin (out_margin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NC*W-1:0] pack5(input int a, input int b, input int c,
                                            input int d, input int e);
    logic [NC*W-1:0] v;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    v[4*W +: W] = W'(e);
    return v;
  endfunction

  // Reference: first pass finds the lowest-index maximum, second pass the
  // largest of the remaining logits; margin is their difference.
  function automatic void model(input logic [NC*W-1:0] v, output int idx,
                                output longint mx, output longint mg);
    longint best, sec, val;
    best = longint'($signed(v[0 +: W]));
    idx  = 0;
    for (int k = 1; k < NC; k++) begin
      val = longint'($signed(v[k*W +: W]));
      if (val > best) begin
        best = val;
        idx  = k;
      end
    end
    sec = -(longint'(1) << 40);
    for (int k = 0; k < NC; k++) begin
      val = longint'($signed(v[k*W +: W]));
      if (k != idx && val > sec) sec = val;
    end
    mx = best;
`ifdef DENSE_ARGMAX_MARGIN_EN
    mg = best - sec;
`else
    mg = 0;
`endif
  endfunction

  function automatic logic [NC*W-1:0] rand_vec();
    logic [NC*W-1:0] v;
    int mode;
    int pick;
    for (int k = 0; k < NC; k++) begin
      mode = int'($urandom_range(0, 2));
      pick = int'($urandom_range(0, 3));
      case (mode)
        0: v[k*W +: W] = W'($urandom);
        1: v[k*W +: W] = W'(int'($urandom_range(0, 6)) - 3);
        default: v[k*W +: W] = (pick == 0) ? {1'b1, {(W-1){1'b0}}} :
                               (pick == 1) ? {1'b0, {(W-1){1'b1}}} :
                               (pick == 2) ? W'(0) : {W{1'b1}};
      endcase
    end
    return v;
  endfunction

  // Waits (bounded) for in_ready, then presents v for exactly one accept edge.
  task automatic issue(input logic [NC*W-1:0] v, input string name);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_wait: in_ready=%b required 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_logits = v;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    in_valid  = 1'b0;
    in_logits = (NC*W)'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input logic [NC*W-1:0] v, input string name);
    int idx, lat;
    longint mx, mg;
    model(v, idx, mx, mg);
    issue(v, name);
    wait_result(lat);
    checks++;
    if (lat !== NC - 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (valid=%b) required %0d", name, lat, out_valid, NC-1);
    end
    checks++;
    if (out_idx !== IW'(idx)) begin
      errors++;
      $display("FAIL %s idx: got %0d required %0d", name, out_idx, idx);
    end
    checks++;
    if (out_max !== W'(mx)) begin
      errors++;
      $display("FAIL %s max: got %0d required %0d", name, out_max, mx);
    end
    checks++;
    if (out_margin !== (W+1)'(mg)) begin
      errors++;
      $display("FAIL %s margin: got %0d required %0d", name, out_margin, mg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_logits = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_idx !== '0 || out_max !== '0 || out_margin !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_out: idx=%0d max=%0d margin=%0d in_ready=%b required 0/0/0/1",
               out_idx, out_max, out_margin, in_ready);
    end
  endtask

  task automatic test_directed();
    run_vec(pack5(-64, -65, -72, 84, 220), "dir_pos_win");
    run_vec(pack5(0, 0, 0, 0, 0), "dir_all_zero");
    run_vec(pack5(-1024, -512, -2048, -300, -700), "dir_all_neg");
    run_vec(pack5(-(1 << 20), -(1 << 20), (1 << 20) - 1, -(1 << 20), -(1 << 20)), "dir_extreme");
    run_vec(pack5(7, 3, 7, 7, 2), "dir_tie_first");
  endtask

  task automatic test_back_to_back();
    int prev;
    for (int i = 0; i < 30; i++) begin
      run_vec(rand_vec(), "rand");
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev !== NC + 1) begin
          errors++;
          $display("FAIL rand_interval: got %0d cycles required %0d", acc_cyc - prev, NC + 1);
        end
      end
      prev = acc_cyc;
    end
  endtask

  task automatic test_backpressure();
    logic [NC*W-1:0] va, vb;
    int idx, lat;
    longint mx, mg;
    va = pack5(100, -5, 300, 299, 12);
    vb = rand_vec();
    model(va, idx, mx, mg);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(va, "bp_a");
    wait_result(lat);
    in_valid  = 1'b1;
    in_logits = vb;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== IW'(idx) ||
          out_max !== W'(mx) || out_margin !== (W+1)'(mg)) begin
        errors++;
        $display("FAIL bp_hold: valid=%b ready=%b idx=%0d max=%0d margin=%0d required 1/0/%0d/%0d/%0d",
                 out_valid, in_ready, out_idx, out_max, out_margin, idx, mx, mg);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    model(vb, idx, mx, mg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if (lat !== NC - 1 || out_idx !== IW'(idx) || out_max !== W'(mx) || out_margin !== (W+1)'(mg)) begin
      errors++;
      $display("FAIL bp_second: lat=%0d idx=%0d max=%0d margin=%0d required %0d/%0d/%0d/%0d",
               lat, out_idx, out_max, out_margin, NC-1, idx, mx, mg);
    end
  endtask

  task automatic test_reset_abort();
    logic seen = 1'b0;
    @(posedge clk); #1;
    issue(pack5(1, 2, 3, 4, 5), "abort");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_output: out_valid rose=%b required 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1 || out_idx !== '0 || out_max !== '0 || out_margin !== '0) begin
      errors++;
      $display("FAIL abort_state: ready=%b idx=%0d max=%0d margin=%0d required 1/0/0/0",
               in_ready, out_idx, out_max, out_margin);
    end
    run_vec(pack5(0, 0, 0, 0, 5), "abort_next");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
